seg_display_scan: RTL and testbench

// - Consumer side of the display refresh tick: scans a multiplexed common-anode 7-segment display, one digit per tick.
// - Converts hex nibbles to segment patterns and drives anodes/cathodes with a dead-time gap to stop ghosting.
// - Sits between user datapath (value to show) and board pins; tick comes from the display refresh-rate tick generator.

---
 rtl/seg_display_scan.sv | 201 ++++++++++++++++++++
 tb/tb_seg_display_scan.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// seg_display_scan
// Scans a multiplexed common-anode 7-segment display, one digit per refresh tick.
// The display value is converted from hex nibbles to segment patterns. Between
// digits, all anodes are held off for a dead-time gap so the previous digit's
// pattern does not ghost onto the next one.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   tick         1-cycle refresh pulse that advances the scan to the next digit
//   value        4*NUM_DIGITS hex digits; value[3:0] is digit 0 (rightmost)
//   dp_in        decimal point per digit, 1 = lit
//   digit_en     per-digit enable, 0 = digit blanked
//   anode        digit select, polarity set by ACTIVE_LOW
//   cathode      [0]=CA..[6]=CG, [7]=DP, polarity set by ACTIVE_LOW
//   frame_start  1-cycle pulse when the digit 0 slot begins (shadow regs loaded)
//
// Optional feature
//   SEG_LZB_EN   when defined, leading zero digits of the frame are blanked
//                (digit 0 is never blanked, and a lit decimal point ends the run)

module seg_display_scan #(
    parameter int NUM_DIGITS  = 8,
    parameter int DEAD_CYCLES = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic                    frame_start
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [7:0]            CATH_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    generate
        if (DEAD_CYCLES < 1) begin : g_badDeadCycles
            $error("seg_display_scan: DEAD_CYCLES must be at least 1");
        end
        if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_badNumDigits
            $error("seg_display_scan: NUM_DIGITS must be in 2..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        ON
    } state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic [CW-1:0]           r_deadCnt;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_en;

    logic                    w_load;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic                    w_show;
    logic [6:0]              w_segs;
    logic [NUM_DIGITS-1:0]   w_anodeOn;
    logic [7:0]              w_cathodeOn;

`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   w_lzbMask;
    logic                    w_lzbRun;

    // Walk down from the most significant digit while the nibbles are zero
    // and have no decimal point; those digits are blanked for the frame.
    // Digit 0 is excluded so a zero value still shows a single '0'.
    always_comb begin
        w_lzbMask = '0;
        w_lzbRun  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (w_lzbRun && (value[4*i +: 4] == 4'h0) && !dp_in[i]) begin
                w_lzbMask[i] = 1'b1;
            end else begin
                w_lzbRun = 1'b0;
            end
        end
    end

    assign w_show = r_en[r_idx] & ~r_blank[r_idx];
`else
    assign w_show = r_en[r_idx];
`endif

    // A new frame begins whenever the scan lands on digit 0: either leaving
    // IDLE or wrapping past the last digit. Inputs are captured only then.
    assign w_load = tick && ((r_state == IDLE) || ((r_state == ON) && (r_idx == LAST_IDX)));

    assign w_nibble = 4'(r_value >> {r_idx, 2'b00});
    assign w_dp     = r_dp[r_idx];

    // Active-high segment patterns, bit 0 = CA .. bit 6 = CG.
    always_comb begin
        w_segs = 7'h00;
        case (w_nibble)
            4'h0: w_segs = 7'h3F;
            4'h1: w_segs = 7'h06;
            4'h2: w_segs = 7'h5B;
            4'h3: w_segs = 7'h4F;
            4'h4: w_segs = 7'h66;
            4'h5: w_segs = 7'h6D;
            4'h6: w_segs = 7'h7D;
            4'h7: w_segs = 7'h07;
            4'h8: w_segs = 7'h7F;
            4'h9: w_segs = 7'h6F;
            4'hA: w_segs = 7'h77;
            4'hB: w_segs = 7'h7C;
            4'hC: w_segs = 7'h39;
            4'hD: w_segs = 7'h5E;
            4'hE: w_segs = 7'h79;
            4'hF: w_segs = 7'h71;
            default: w_segs = 7'h00;
        endcase
    end

    // XOR with the "off" pattern converts the active-high view to the board polarity.
    assign w_anodeOn   = w_show ? ((NUM_DIGITS'(1) << r_idx) ^ ANODE_OFF) : ANODE_OFF;
    assign w_cathodeOn = w_show ? ({w_dp, w_segs} ^ CATH_OFF) : CATH_OFF;

    // Scan FSM with registered outputs. The dead counter loads DEAD_CYCLES on
    // the tick and the ON slot starts after it reaches zero, so a tick in cycle
    // T shows the new digit at T+DEAD_CYCLES+2. Ticks during DEAD are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_deadCnt   <= '0;
            r_value     <= '0;
            r_dp        <= '0;
            r_en        <= '0;
            anode       <= ANODE_OFF;
            cathode     <= CATH_OFF;
            frame_start <= 1'b0;
`ifdef SEG_LZB_EN
            r_blank     <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    anode   <= ANODE_OFF;
                    cathode <= CATH_OFF;
                    if (tick) begin
                        r_state   <= DEAD;
                        r_idx     <= '0;
                        r_deadCnt <= DEAD_LOAD;
                    end
                end
                DEAD: begin
                    if (r_deadCnt == '0) begin
                        r_state <= ON;
                        anode   <= w_anodeOn;
                        cathode <= w_cathodeOn;
                    end else begin
                        r_deadCnt <= r_deadCnt - CW'(1);
                    end
                end
                ON: begin
                    if (tick) begin
                        r_state   <= DEAD;
                        r_deadCnt <= DEAD_LOAD;
                        anode     <= ANODE_OFF;
                        cathode   <= CATH_OFF;
                        r_idx     <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    anode   <= ANODE_OFF;
                    cathode <= CATH_OFF;
                end
            endcase

            if (w_load) begin
                r_value     <= value;
                r_dp        <= dp_in;
                r_en        <= digit_en;
                frame_start <= 1'b1;
`ifdef SEG_LZB_EN
                r_blank     <= w_lzbMask;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan
// Directed bench for seg_display_scan with 8 digits, 4 dead cycles and
// active-low outputs. Expected segment codes are hand-computed constants.
// Expectations for the leading-zero section follow SEG_LZB_EN.

module tb_seg_display_scan;

    localparam int NUM_DIGITS  = 8;
    localparam int DEAD_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [31:0] value;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic [7:0]  anode;
    logic [7:0]  cathode;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_display_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .DEAD_CYCLES(DEAD_CYCLES),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .anode      (anode),
        .cathode    (cathode),
        .frame_start(frame_start)
    );

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Issues one tick and follows the resulting slot: first and last dead
    // cycles must be dark, then the digit must appear exactly one cycle later.
    // extraTick puts a second tick into the dead gap, which must be ignored.
    task automatic applyStimulus(input string tag, input logic [7:0] expAnode,
                                 input logic [7:0] expCathode, input logic expFs,
                                 input logic extraTick);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        checkOutput({tag, "_fs"}, 32'(frame_start), 32'(expFs));
        checkOutput({tag, "_deadFirstAnode"}, 32'(anode), 32'hFF);
        checkOutput({tag, "_deadFirstCathode"}, 32'(cathode), 32'hFF);
        if (extraTick) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
            repeat (DEAD_CYCLES - 2) @(negedge clk);
        end else begin
            repeat (DEAD_CYCLES) @(negedge clk);
        end
        checkOutput({tag, "_deadLastAnode"}, 32'(anode), 32'hFF);
        @(negedge clk);
        checkOutput({tag, "_anode"}, 32'(anode), 32'(expAnode));
        if (expAnode != 8'hFF) begin
            checkOutput({tag, "_cathode"}, 32'(cathode), 32'(expCathode));
        end
        checkOutput({tag, "_fsLow"}, 32'(frame_start), 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst  = 1'b1;
        tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] anodeFor(input int idx);
        logic [7:0] oneHot;
        oneHot = 8'h01 << idx;
        return ~oneHot;
    endfunction

    logic [7:0] cathScan [8];
    logic [7:0] cathBeef [4];

    initial begin
        // Digits of 1234_5678 from digit 0 upward: 8,7,6,5,4,3,2,1.
        cathScan = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        // Digits of DEAD_BEEF from digit 0 upward: F,E,E,B.
        cathBeef = '{8'h8E, 8'h86, 8'h86, 8'h83};

        rst      = 1'b1;
        tick     = 1'b0;
        value    = 32'h1234_5678;
        dp_in    = 8'h00;
        digit_en = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state holds with no ticks.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0 || i == 5) begin
                checkOutput($sformatf("reset%0d_anode", i), 32'(anode), 32'hFF);
                checkOutput($sformatf("reset%0d_cathode", i), 32'(cathode), 32'hFF);
                checkOutput($sformatf("reset%0d_fs", i), 32'(frame_start), 32'h0);
            end
        end

        // Full scan of 1234_5678; new value presented mid-frame at idx 3.
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("scan%0d", i), anodeFor(i), cathScan[i], i == 0, 1'b0);
            if (i == 3) value = 32'hDEAD_BEEF;
        end

        // Wrap: new frame shows DEAD_BEEF; extra tick in the dead gap at idx 2.
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("beef%0d", i), anodeFor(i), cathBeef[i], i == 0, i == 2);
        end

        // Reset mid-scan blanks immediately and stays idle.
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checkOutput("midReset_anode", 32'(anode), 32'hFF);
        checkOutput("midReset_cathode", 32'(cathode), 32'hFF);
        checkOutput("midReset_fs", 32'(frame_start), 32'h0);
        repeat (5) @(negedge clk);
        checkOutput("midResetIdle_anode", 32'(anode), 32'hFF);

        // Blanking of digits 4..7 and decimal point on digit 0.
        value    = 32'h1234_5678;
        digit_en = 8'h0F;
        dp_in    = 8'h01;
        applyStimulus("blank0", 8'hFE, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus($sformatf("blank%0d", i), (i < 4) ? anodeFor(i) : 8'hFF,
                          cathScan[i], 1'b0, 1'b0);
        end

        // Leading zeros: 0000_0042 then 0000_0000.
        resetDut();
        value    = 32'h0000_0042;
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        applyStimulus("lzb42_0", 8'hFE, 8'hA4, 1'b1, 1'b0);
        applyStimulus("lzb42_1", 8'hFD, 8'h99, 1'b0, 1'b0);
        for (int i = 2; i < 8; i++) begin
`ifdef SEG_LZB_EN
            applyStimulus($sformatf("lzb42_%0d", i), 8'hFF, 8'hC0, 1'b0, 1'b0);
`else
            applyStimulus($sformatf("lzb42_%0d", i), anodeFor(i), 8'hC0, 1'b0, 1'b0);
`endif
            if (i == 3) value = 32'h0000_0000;
        end
        applyStimulus("lzb0_0", 8'hFE, 8'hC0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
`ifdef SEG_LZB_EN
            applyStimulus($sformatf("lzb0_%0d", i), 8'hFF, 8'hC0, 1'b0, 1'b0);
`else
            applyStimulus($sformatf("lzb0_%0d", i), anodeFor(i), 8'hC0, 1'b0, 1'b0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
